// File: rtl/flappy_pkg.sv
// Shared constants and state encoding for the flappy-bird game blocks.
package flappy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b001,
    ST_FLIGHT = 3'b010,
    ST_STOP   = 3'b100
  } state_t;

  localparam int unsigned FRAC_W_DEF  = 4;
  localparam int unsigned SCREEN_H_PX = 480;
  localparam int unsigned SCREEN_W_PX = 640;
  localparam int unsigned SPRITE_W    = 20;
  localparam int unsigned SPRITE_H    = 20;

endpackage

// File: rtl/fp_clamp_add.sv
// Signed position + velocity add, clamped to [0, HI_LIMIT] with hit flags.
module fp_clamp_add #(
  parameter int unsigned P_W      = 14,
  parameter int unsigned HI_LIMIT = 7360
) (
  input  logic [P_W-1:0]        p,
  input  logic signed [P_W:0]   v,
  output logic [P_W-1:0]        sum_c,
  output logic                  hit_lo_c,
  output logic                  hit_hi_c
);

  localparam logic signed [P_W:0] HI_S = (P_W+1)'(HI_LIMIT);

  logic signed [P_W:0] s;

  always_comb begin
    s        = $signed({1'b0, p}) + v;
    hit_lo_c = s[P_W];
    hit_hi_c = !s[P_W] && (s > HI_S);
    if (hit_lo_c)      sum_c = '0;
    else if (hit_hi_c) sum_c = HI_S[P_W-1:0];
    else               sum_c = s[P_W-1:0];
  end

endmodule

// File: rtl/bird_motion_ctrl.sv
// Bird flight physics: fixed-point gravity/flap integration per frame tick.
// Optional flap lockout enabled by defining FLAP_COOLDOWN_EN.
module bird_motion_ctrl
  import flappy_pkg::*;
#(
  parameter int unsigned Y_W            = 10,
  parameter int unsigned FRAC_W         = FRAC_W_DEF,
  parameter int unsigned GRAVITY        = 3,
  parameter int unsigned JUMP_VEL       = 40,
  parameter int unsigned V_MAX          = 96,
  parameter int unsigned BIRD_X         = 300,
  parameter int unsigned BIRD_W         = SPRITE_W,
  parameter int unsigned BIRD_H         = SPRITE_H,
  parameter int unsigned Y_START        = 220,
  parameter int unsigned SCREEN_H       = SCREEN_H_PX,
  parameter int unsigned COOLDOWN_TICKS = 4
) (
  input  logic                        Clk,
  input  logic                        reset,
  input  logic                        Start,
  input  logic                        Stop,
  input  logic                        Ack,
  input  logic                        Tick,
  input  logic                        BtnPress,
  output logic [Y_W-1:0]              Bird_X_L,
  output logic [Y_W-1:0]              Bird_X_R,
  output logic [Y_W-1:0]              Bird_Y_T,
  output logic [Y_W-1:0]              Bird_Y_B,
  output logic signed [Y_W+FRAC_W:0]  Velocity,
  output logic                        HitFloor,
  output logic                        HitCeiling,
  output logic                        q_Initial,
  output logic                        q_Flight,
  output logic                        q_Stop
);

  localparam int unsigned P_W   = Y_W + FRAC_W;
  localparam int unsigned V_W   = P_W + 1;
  localparam int unsigned P_TOP = (SCREEN_H - BIRD_H) << FRAC_W;

  localparam logic [P_W-1:0]        P_INIT = P_W'(Y_START << FRAC_W);
  localparam logic signed [V_W-1:0] GRAV_V = V_W'(GRAVITY);
  localparam logic signed [V_W-1:0] JUMP_V = V_W'(JUMP_VEL);
  localparam logic signed [V_W-1:0] VMAX_V = V_W'(V_MAX);

  state_t                state_q, state_d;
  logic [P_W-1:0]        p_q, p_d, sum_c;
  logic signed [V_W-1:0] v_q, v_d, v_new, v_grav;
  logic                  latch_q, latch_d;
  logic                  hit_f_q, hit_f_d, hit_c_q, hit_c_d;
  logic                  hit_lo_c, hit_hi_c;
  logic [Y_W-1:0]        y_t_q, y_b_q;
  logic                  flap_ok;

`ifdef FLAP_COOLDOWN_EN
  localparam int unsigned CD_W = $clog2(COOLDOWN_TICKS + 1);

  logic [CD_W-1:0] cd_q, cd_d;

  assign flap_ok = (latch_q | BtnPress) && (cd_q == '0);

  // Lockout counter: load on an accepted flap tick, count down on later ticks.
  always_comb begin
    cd_d = cd_q;
    if (state_q == ST_IDLE) begin
      cd_d = '0;
    end else if (state_q == ST_FLIGHT && Tick && !Stop) begin
      if (flap_ok)           cd_d = CD_W'(COOLDOWN_TICKS);
      else if (cd_q != '0)   cd_d = cd_q - 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) cd_q <= '0;
    else       cd_q <= cd_d;
  end
`else
  assign flap_ok = latch_q | BtnPress;
`endif

  // Candidate velocity for this tick: flap impulse or gravity with terminal clamp.
  always_comb begin
    v_grav = v_q + GRAV_V;
    v_new  = v_grav;
    if (flap_ok)               v_new = -JUMP_V;
    else if (v_grav > VMAX_V)  v_new = VMAX_V;
  end

  fp_clamp_add #(
    .P_W      (P_W),
    .HI_LIMIT (P_TOP)
  ) u_clamp (
    .p        (p_q),
    .v        (v_new),
    .sum_c    (sum_c),
    .hit_lo_c (hit_lo_c),
    .hit_hi_c (hit_hi_c)
  );

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    v_d     = v_q;
    latch_d = 1'b0;
    hit_f_d = 1'b0;
    hit_c_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        p_d = P_INIT;
        v_d = '0;
        if (Start) state_d = ST_FLIGHT;
      end
      ST_FLIGHT: begin
        if (Stop) begin
          state_d = ST_STOP;
        end else if (Tick) begin
          p_d     = sum_c;
          v_d     = (hit_lo_c || hit_hi_c) ? '0 : v_new;
          hit_c_d = hit_lo_c;
          hit_f_d = hit_hi_c;
        end else begin
          latch_d = latch_q | BtnPress;
        end
      end
      ST_STOP: begin
        if (Ack) begin
          state_d = ST_IDLE;
          p_d     = P_INIT;
          v_d     = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      p_q     <= P_INIT;
      v_q     <= '0;
      latch_q <= 1'b0;
      hit_f_q <= 1'b0;
      hit_c_q <= 1'b0;
      y_t_q   <= Y_W'(Y_START);
      y_b_q   <= Y_W'(Y_START + BIRD_H);
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      v_q     <= v_d;
      latch_q <= latch_d;
      hit_f_q <= hit_f_d;
      hit_c_q <= hit_c_d;
      y_t_q   <= p_d[P_W-1:FRAC_W];
      y_b_q   <= p_d[P_W-1:FRAC_W] + Y_W'(BIRD_H);
    end
  end

  assign Bird_X_L   = Y_W'(BIRD_X);
  assign Bird_X_R   = Y_W'(BIRD_X + BIRD_W);
  assign Bird_Y_T   = y_t_q;
  assign Bird_Y_B   = y_b_q;
  assign Velocity   = v_q;
  assign HitFloor   = hit_f_q;
  assign HitCeiling = hit_c_q;
  assign q_Initial  = state_q[0];
  assign q_Flight   = state_q[1];
  assign q_Stop     = state_q[2];

endmodule

// File: tb/tb_bird_motion_ctrl.sv
// Directed self-checking bench for bird_motion_ctrl.
module tb_bird_motion_ctrl;

  logic               Clk = 1'b0;
  logic               reset = 1'b0;
  logic               Start = 1'b0;
  logic               Stop = 1'b0;
  logic               Ack = 1'b0;
  logic               Tick = 1'b0;
  logic               BtnPress = 1'b0;
  logic [9:0]         Bird_X_L, Bird_X_R, Bird_Y_T, Bird_Y_B;
  logic signed [14:0] Velocity;
  logic               HitFloor, HitCeiling;
  logic               q_Initial, q_Flight, q_Stop;

  int n_checks = 0;
  int n_fail   = 0;

  bird_motion_ctrl dut (
    .Clk        (Clk),
    .reset      (reset),
    .Start      (Start),
    .Stop       (Stop),
    .Ack        (Ack),
    .Tick       (Tick),
    .BtnPress   (BtnPress),
    .Bird_X_L   (Bird_X_L),
    .Bird_X_R   (Bird_X_R),
    .Bird_Y_T   (Bird_Y_T),
    .Bird_Y_B   (Bird_Y_B),
    .Velocity   (Velocity),
    .HitFloor   (HitFloor),
    .HitCeiling (HitCeiling),
    .q_Initial  (q_Initial),
    .q_Flight   (q_Flight),
    .q_Stop     (q_Stop)
  );

  always #5 Clk = ~Clk;

  // One clock with the given Tick/BtnPress levels; outputs settle 1 time unit after the edge.
  task automatic step(input logic t, input logic b);
    Tick = t; BtnPress = b;
    @(posedge Clk); #1;
    Tick = 1'b0; BtnPress = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic do_start();
    Start = 1'b1;
    step(1'b0, 1'b0);
    Start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (q_Initial !== 1'b1) begin n_fail++; $display("FAIL reset_q_initial got %0b exp 1", q_Initial); end
    n_checks++; if (Bird_X_L !== 10'd300) begin n_fail++; $display("FAIL reset_x_l got %0d exp 300", Bird_X_L); end
    n_checks++; if (Bird_X_R !== 10'd320) begin n_fail++; $display("FAIL reset_x_r got %0d exp 320", Bird_X_R); end
    n_checks++; if (Bird_Y_T !== 10'd220) begin n_fail++; $display("FAIL reset_y_t got %0d exp 220", Bird_Y_T); end
    n_checks++; if (Bird_Y_B !== 10'd240) begin n_fail++; $display("FAIL reset_y_b got %0d exp 240", Bird_Y_B); end
    n_checks++; if (Velocity !== 15'sd0) begin n_fail++; $display("FAIL reset_vel got %0d exp 0", Velocity); end
    n_checks++; if (HitFloor !== 1'b0 || HitCeiling !== 1'b0) begin n_fail++; $display("FAIL reset_hits got %0b%0b exp 00", HitFloor, HitCeiling); end
    // IDLE ignores ticks and presses
    step(1'b1, 1'b1);
    n_checks++; if (q_Initial !== 1'b1 || Velocity !== 15'sd0 || Bird_Y_T !== 10'd220) begin
      n_fail++; $display("FAIL idle_hold got q=%0b v=%0d y=%0d exp q=1 v=0 y=220", q_Initial, Velocity, Bird_Y_T); end
  endtask

  task automatic test_gravity();
    int exp_v[4] = '{3, 6, 9, 12};
    int exp_y[4] = '{220, 220, 221, 221};
    do_reset();
    do_start();
    n_checks++; if (q_Flight !== 1'b1) begin n_fail++; $display("FAIL start_q_flight got %0b exp 1", q_Flight); end
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0);
      n_checks++; if (Velocity !== 15'(exp_v[k]) || Bird_Y_T !== 10'(exp_y[k])) begin
        n_fail++; $display("FAIL gravity_tick%0d got v=%0d y=%0d exp v=%0d y=%0d", k, Velocity, Bird_Y_T, exp_v[k], exp_y[k]); end
    end
    n_checks++; if (Bird_Y_B !== 10'd241) begin n_fail++; $display("FAIL gravity_y_b got %0d exp 241", Bird_Y_B); end
    step(1'b0, 1'b0);
    n_checks++; if (Velocity !== 15'sd12 || Bird_Y_T !== 10'd221) begin
      n_fail++; $display("FAIL between_ticks got v=%0d y=%0d exp v=12 y=221", Velocity, Bird_Y_T); end
  endtask

  task automatic test_flap();
    do_reset();
    do_start();
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    n_checks++; if (Velocity !== -15'sd40 || Bird_Y_T !== 10'd217) begin
      n_fail++; $display("FAIL flap_latched got v=%0d y=%0d exp v=-40 y=217", Velocity, Bird_Y_T); end
    step(1'b1, 1'b0);
    n_checks++; if (Velocity !== -15'sd37 || Bird_Y_T !== 10'd215) begin
      n_fail++; $display("FAIL flap_next got v=%0d y=%0d exp v=-37 y=215", Velocity, Bird_Y_T); end
  endtask

  task automatic test_floor_ceiling();
    int vmax = 0;
    int n = 0;
    int hits = 0;
    do_reset();
    do_start();
    while (HitFloor !== 1'b1 && n < 200) begin
      step(1'b1, 1'b0);
      if (Velocity > vmax) vmax = Velocity;
      n++;
    end
    n_checks++; if (HitFloor !== 1'b1) begin n_fail++; $display("FAIL floor_timeout got HitFloor=%0b exp 1", HitFloor); end
    n_checks++; if (vmax !== 96) begin n_fail++; $display("FAIL terminal_vel got %0d exp 96", vmax); end
    n_checks++; if (Bird_Y_T !== 10'd460 || Bird_Y_B !== 10'd480 || Velocity !== 15'sd0) begin
      n_fail++; $display("FAIL floor_clamp got y_t=%0d y_b=%0d v=%0d exp 460 480 0", Bird_Y_T, Bird_Y_B, Velocity); end
    step(1'b0, 1'b0);
    n_checks++; if (HitFloor !== 1'b0) begin n_fail++; $display("FAIL floor_pulse_width got %0b exp 0", HitFloor); end
    // 7360 / 40 = 184 flaps land exactly on 0 without a hit; the 185th clamps
    n = 0;
    while (HitCeiling !== 1'b1 && n < 300) begin
      step(1'b1, 1'b1);
      n++;
      if (HitCeiling === 1'b1) hits++;
    end
    n_checks++; if (n !== 185) begin n_fail++; $display("FAIL ceiling_tick_count got %0d exp 185", n); end
    n_checks++; if (Bird_Y_T !== 10'd0 || Velocity !== 15'sd0) begin
      n_fail++; $display("FAIL ceiling_clamp got y=%0d v=%0d exp 0 0", Bird_Y_T, Velocity); end
    step(1'b0, 1'b0);
    if (HitCeiling === 1'b1) hits++;
    step(1'b0, 1'b0);
    if (HitCeiling === 1'b1) hits++;
    n_checks++; if (hits !== 1) begin n_fail++; $display("FAIL ceiling_pulse_count got %0d exp 1", hits); end
  endtask

  task automatic test_stop_ack();
    do_reset();
    do_start();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    Stop = 1'b1;
    step(1'b1, 1'b0);
    Stop = 1'b0;
    n_checks++; if (q_Stop !== 1'b1 || Bird_Y_T !== 10'd220 || Velocity !== 15'sd6) begin
      n_fail++; $display("FAIL stop_priority got q=%0b y=%0d v=%0d exp q=1 y=220 v=6", q_Stop, Bird_Y_T, Velocity); end
    step(1'b1, 1'b1);
    n_checks++; if (Velocity !== 15'sd6 || Bird_Y_T !== 10'd220) begin
      n_fail++; $display("FAIL stop_frozen got y=%0d v=%0d exp y=220 v=6", Bird_Y_T, Velocity); end
    Ack = 1'b1;
    step(1'b0, 1'b0);
    Ack = 1'b0;
    n_checks++; if (q_Initial !== 1'b1) begin n_fail++; $display("FAIL ack_idle got %0b exp 1", q_Initial); end
    step(1'b0, 1'b0);
    n_checks++; if (Bird_Y_T !== 10'd220 || Velocity !== 15'sd0) begin
      n_fail++; $display("FAIL ack_reload got y=%0d v=%0d exp y=220 v=0", Bird_Y_T, Velocity); end
    // reset mid-flight
    do_start();
    step(1'b1, 1'b1);
    n_checks++; if (Bird_Y_T !== 10'd217) begin n_fail++; $display("FAIL pre_reset_flap got %0d exp 217", Bird_Y_T); end
    do_reset();
    n_checks++; if (q_Initial !== 1'b1 || Bird_Y_T !== 10'd220 || Velocity !== 15'sd0) begin
      n_fail++; $display("FAIL midflight_reset got q=%0b y=%0d v=%0d exp 1 220 0", q_Initial, Bird_Y_T, Velocity); end
  endtask

  task automatic test_cooldown();
`ifdef FLAP_COOLDOWN_EN
    int exp_t2 = -34;
`else
    int exp_t2 = -40;
`endif
    do_reset();
    do_start();
    step(1'b1, 1'b1);
    n_checks++; if (Velocity !== -15'sd40) begin n_fail++; $display("FAIL cd_tick0 got %0d exp -40", Velocity); end
    step(1'b1, 1'b0);
    n_checks++; if (Velocity !== -15'sd37) begin n_fail++; $display("FAIL cd_tick1 got %0d exp -37", Velocity); end
    step(1'b1, 1'b1);
    n_checks++; if (Velocity !== 15'(exp_t2)) begin n_fail++; $display("FAIL cd_tick2 got %0d exp %0d", Velocity, exp_t2); end
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    n_checks++; if (Velocity !== -15'sd40) begin n_fail++; $display("FAIL cd_tick5 got %0d exp -40", Velocity); end
  endtask

  initial begin
    #1;
    test_reset();
    test_gravity();
    test_flap();
    test_floor_ceiling();
    test_stop_ack();
    test_cooldown();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
